// File: rtl/conv_window_sequencer.sv
// Convolution window sequencer: walks a SIZE x SIZE index block row-major,
// multiply-accumulates kernel*pixel pairs and emits a rounded, saturated 8-bit result.
module conv_window_sequencer #(
  parameter logic [3:0] SIZE    = 4'd3,
  parameter int         IDX_LAT = 1,
  parameter int         ACC_W   = 20,
  parameter int         SHIFT   = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic       en_strobe,
  input  logic [7:0] kernel_v,
  input  logic [7:0] pixel_v,
  output logic       busy,
  output logic [7:0] result,
  output logic       result_valid,
  input  logic       result_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam int               CNT_W     = (IDX_LAT > 1) ? $clog2(IDX_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(IDX_LAT - 1);
  localparam logic [3:0]       LAST      = SIZE - 4'd1;

  // Half-LSB rounding constant; the nested guard keeps the shift amount legal when SHIFT is 0.
  localparam logic [ACC_W:0] RND     = (SHIFT > 0) ? ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0))
                                                   : '0;
  localparam logic [ACC_W:0] SAT_MAX = (ACC_W+1)'(255);

  logic [2:0]       state_q,  state_d;
  logic [3:0]       x_q,      x_d;
  logic [3:0]       y_q,      y_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [7:0]       result_q, result_d;
  logic             valid_q,  valid_d;
  logic [15:0]      prod;

  function automatic logic [7:0] round_sat(input logic [ACC_W-1:0] a);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + RND;
    sum = sum >> SHIFT;
    return (sum > SAT_MAX) ? 8'hFF : sum[7:0];
  endfunction

  assign prod = kernel_v * pixel_v;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    valid_d  = valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          x_d     = 4'd0;
          y_d     = 4'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = WAIT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_MAC;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (x_q == LAST && y_q == LAST) begin
          // Indices stay at the last element; the next start reloads them.
          result_d = round_sat(acc_d);
          valid_d  = 1'b1;
          state_d  = S_OUT;
        end else begin
          if (x_q == LAST) begin
            x_d = 4'd0;
            y_d = y_q + 4'd1;
          end else begin
            x_d = x_q + 4'd1;
          end
          state_d = S_ISSUE;
        end
      end
      S_OUT: begin
        if (valid_q && result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over everything, but the last delivered result stays visible.
    if (abort) begin
      state_d  = S_IDLE;
      x_d      = 4'd0;
      y_d      = 4'd0;
      cnt_d    = '0;
      acc_d    = '0;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      x_q      <= 4'd0;
      y_q      <= 4'd0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= 8'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign cur_x        = x_q;
  assign cur_y        = y_q;
  assign en_strobe    = (state_q == S_ISSUE);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer with a 1-cycle-latency index block model.
module tb_conv_window_sequencer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cur_x;
  logic [3:0] cur_y;
  logic       en_strobe;
  logic [7:0] kernel_v = 8'd0;
  logic [7:0] pixel_v = 8'd0;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int sx[$];
  int sy[$];
  int sc[$];

  int ktab[3][3] = '{'{25, 29, 25}, '{29, 33, 29}, '{25, 29, 25}};
  int ptab[3][3] = '{'{25, 100, 25}, '{50, 150, 50}, '{25, 100, 25}};
  int ex[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int ey[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

  bit all255 = 1'b0;
  bit pend = 1'b0;
  int px = 0;
  int py = 0;

  conv_window_sequencer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .abort        (abort),
    .cur_x        (cur_x),
    .cur_y        (cur_y),
    .en_strobe    (en_strobe),
    .kernel_v     (kernel_v),
    .pixel_v      (pixel_v),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Index block: garbage while the request is in flight, data one cycle after the strobe.
  always @(negedge clk) begin
    if (en_strobe) begin
      sx.push_back(int'(cur_x));
      sy.push_back(int'(cur_y));
      sc.push_back(cyc);
      px = int'(cur_x);
      py = int'(cur_y);
      pend = 1'b1;
      kernel_v = 8'hA5;
      pixel_v  = 8'h5A;
    end else if (pend) begin
      kernel_v = all255 ? 8'd255 : 8'(ktab[px % 3][py % 3]);
      pixel_v  = all255 ? 8'd255 : 8'(ptab[px % 3][py % 3]);
      pend = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Pulses start for one edge; c0 is the cycle count just before the sampling edge.
  task automatic pulse_start(output int c0);
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      if (result_valid) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic check_strobes(input string tag, input int c0);
    chk({tag, "_nstrobe"}, sx.size(), 9);
    for (int i = 0; i < 9 && i < sx.size(); i++) begin
      chk($sformatf("%s_x%0d", tag, i), sx[i], ex[i]);
      chk($sformatf("%s_y%0d", tag, i), sy[i], ey[i]);
      chk($sformatf("%s_t%0d", tag, i), sc[i] - c0, 1 + 3 * i);
    end
  endtask

  initial begin
    int c0;
    int at;
    int seen_valid;

    // Reset held across two edges
    n_rst = 1'b0;
    tick();
    tick();
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobe", int'(en_strobe), 0);
    chk("rst_x", int'(cur_x), 0);
    chk("rst_y", int'(cur_y), 0);
    n_rst = 1'b1;
    tick();

    // Reference window: acc 16150 -> (16150+128)>>8 = 63
    sx.delete(); sy.delete(); sc.delete();
    all255 = 1'b0;
    pulse_start(c0);
    chk("w1_busy", int'(busy), 1);
    wait_valid(at);
    chk("w1_latency", at - c0, 28);
    check_strobes("w1", c0);
    chk("w1_result", int'(result), 63);
    chk("w1_busy_out", int'(busy), 1);
    chk("w1_strobe_out", int'(en_strobe), 0);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("w1_valid_clr", int'(result_valid), 0);
    chk("w1_busy_idle", int'(busy), 0);
    chk("w1_result_hold", int'(result), 63);

    // All-255 window saturates; then backpressure with an ignored start
    sx.delete(); sy.delete(); sc.delete();
    all255 = 1'b1;
    pulse_start(c0);
    wait_valid(at);
    chk("w2_latency", at - c0, 28);
    chk("w2_nstrobe", sx.size(), 9);
    chk("w2_result", int'(result), 255);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      chk($sformatf("bp_valid%0d", i), int'(result_valid), 1);
      chk($sformatf("bp_result%0d", i), int'(result), 255);
      chk($sformatf("bp_busy%0d", i), int'(busy), 1);
    end
    start = 1'b0;
    chk("bp_nstrobe", sx.size(), 9);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("bp_valid_clr", int'(result_valid), 0);
    chk("bp_busy_idle", int'(busy), 0);
    tick();
    tick();
    chk("bp_no_queue", int'(busy), 0);
    chk("bp_nstrobe_after", sx.size(), 9);

    // Abort during the 5th strobe, then a clean window
    sx.delete(); sy.delete(); sc.delete();
    all255 = 1'b0;
    pulse_start(c0);
    for (int i = 0; i < 100; i++) begin
      if (sx.size() >= 5) break;
      tick();
    end
    chk("ab_at5", sx.size(), 5);
    chk("ab_strobe_live", int'(en_strobe), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_strobe", int'(en_strobe), 0);
    chk("ab_valid", int'(result_valid), 0);
    chk("ab_result_hold", int'(result), 255);
    chk("ab_x", int'(cur_x), 0);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (result_valid) seen_valid = 1;
    end
    chk("ab_no_valid", seen_valid, 0);
    chk("ab_nstrobe", sx.size(), 5);

    sx.delete(); sy.delete(); sc.delete();
    pulse_start(c0);
    wait_valid(at);
    chk("w3_latency", at - c0, 28);
    check_strobes("w3", c0);
    chk("w3_result", int'(result), 63);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("w3_busy_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
